// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and sizing helpers for the bit-serial arithmetic cells
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A one-bit operand still needs a one-bit counter to hold the compare value.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ c;
  assign co  = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder with start/done handshake
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             fa_sum, fa_co;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .a   (opa_q[0]),
    .b   (opb_q[0]),
    .c   (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_sum;
    end else begin : g_res_wn
      assign res_next = {fa_sum, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_co;
        res_d   = res_next;
        cnt_d   = cnt_q + CW'(1);
        // Outputs only change here, so a consumer never observes partial bits.
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          sum_d   = res_next;
          cout_d  = fa_co;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - random and directed checks of serial_adder against an arithmetic reference
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, cin, busy, done, cout;
  logic [W-1:0] a, b, sum;
  logic         s4, c4, busy4, done4, cout4;
  logic [3:0]   a4, b4, sum4;
  logic         s1, c1, busy1, done1, cout1;
  logic [0:0]   a1, b1, sum1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [W:0] held;
  logic [4:0] sb4[$];
  logic [1:0] sb1[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .cin(c4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (sb4.size() == 0) check("w4_unexpected_done", done4, 0);
      else                 check("w4_sum", {cout4, sum4}, sb4.pop_front());
    end
    if (rst_n && done1) begin
      if (sb1.size() == 0) check("w1_unexpected_done", done1, 0);
      else                 check("w1_sum", {cout1, sum1}, sb1.pop_front());
    end
  end

  task automatic run8(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                      input bit hold, input string tag);
    logic [W:0] exp;
    int         nbusy;
    bit         got;
    exp   = {1'b0, xa} + {1'b0, xb} + (W+1)'(xc);
    a     = xa;
    b     = xb;
    cin   = xc;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    @(negedge clk);
    check({tag, "_accept"}, busy, 1);
    nbusy = 0;
    got   = 0;
    for (int i = 0; i < W + 4 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (done) got = 1;
      else begin
        if (busy) nbusy++;
        check({tag, "_held"}, {cout, sum}, held);
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
      end
    end
    check({tag, "_done"}, got, 1);
    check({tag, "_busy_cycles"}, nbusy, W);
    check({tag, "_result"}, {cout, sum}, exp);
    held = exp;
    @(negedge clk);
    check({tag, "_idle"}, {busy, done}, 0);
    start = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    rst_n = 1'b0;
    start = 1'b1;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'b1;
    s4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    s1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    held = '0;
    repeat (3) @(negedge clk);
    check("rst_state", {busy, done, cout, sum}, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", {busy, done}, 0);
    end

    run8(8'h3C, 8'h25, 1'b0, 0, "basic");
    run8(8'hFF, 8'h01, 1'b0, 0, "carry1");
    run8(8'hFF, 8'hFF, 1'b1, 0, "carry2");
    run8(8'h00, 8'h00, 1'b0, 1, "hold_start");
    run8(8'hA5, 8'h5A, 1'b1, 0, "b2b_first");
    run8(8'h12, 8'h34, 1'b0, 0, "b2b_second");

    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrst_out", {busy, done, cout, sum}, 0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_nodone", done, 0);
    end
    rst_n = 1'b1;
    held  = '0;
    @(negedge clk);
    check("midrst_idle", {busy, done}, 0);
    run8(8'h80, 8'h80, 1'b0, 0, "fresh");

    for (int i = 0; i < 20; i++)
      run8(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), "rand");

    for (int i = 0; i < 512; i++) begin
      {c4, a4, b4} = 9'(i);
      s4 = 1'b1;
      sb4.push_back(5'(a4) + 5'(b4) + 5'(c4));
      @(posedge clk);
      #1 s4 = 1'b0;
      got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clk);
        got = done4;
      end
      check("w4_done", got, 1);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 8; i++) begin
      {c1, a1, b1} = 3'(i);
      s1 = 1'b1;
      sb1.push_back(2'(a1) + 2'(b1) + 2'(c1));
      @(posedge clk);
      #1 s1 = 1'b0;
      @(negedge clk);
      check("w1_busy", busy1, 1);
      got = 0;
      for (int k = 0; k < 4 && !got; k++) begin
        @(negedge clk);
        got = done1;
      end
      check("w1_done", got, 1);
      @(posedge clk);
      #1;
    end

    repeat (2) @(negedge clk);
    check("sb4_drain", sb4.size(), 0);
    check("sb1_drain", sb1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
